serial_tx_sequencer: RTL and testbench
======================================

SERIAL_TX_SEQUENCER -- requirements
Module: serial_tx_sequencer

Interface
REQ-001 SHALL have parameter: NumbDataBits, 8, width of each input word (>=1).
REQ-002 SHALL have parameter: BitPeriod, 16, Clk cycles each serial bit is held (>=1).
REQ-003 SHALL have port: Clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: ClrN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: Input1  input  NumbDataBits  first word, sent MSB-first.
REQ-006 SHALL have port: Input2  input  NumbDataBits  second word, sent MSB-first after Input1.
REQ-007 SHALL have port: Start  input  1  request to send; sampled only in IDLE.
REQ-008 SHALL have port: Abort  input  1  synchronous cancel of a frame in progress.
REQ-009 SHALL have port: Busy  output  1  high from the cycle after Start acceptance through the DONE cycle.
REQ-010 SHALL have port: BitStrobe  output  1  one-cycle pulse in the first cycle each new bit is driven on OutputBit.
REQ-011 SHALL have port: OutputBit  output  1  serial data, registered; 0 when idle.
REQ-012 SHALL have port: Done  output  1  one-cycle pulse when a frame completes normally.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PARITY (present only with PARITY_EN), and DONE.
REQ-014 In IDLE with Start=1 and Abort=0, SHALL capture {Input1,Input2} into the shift register on that edge and enter SHIFT with bit counter and period counter at 0.
REQ-015 In SHIFT, SHALL drive register bit [2*NumbDataBits-1] on OutputBit and hold each bit for exactly BitPeriod cycles.
REQ-016 At the end of each period, SHALL shift the register left by 1 and increment the bit counter if bits remain; after the last bit's period, SHALL go to PARITY if enabled, else to DONE.
REQ-017 Bit counter width SHALL be $clog2(2*NumbDataBits+1); period counter width SHALL be max(1,$clog2(BitPeriod)); neither SHALL wrap during a frame.
REQ-018 BitStrobe SHALL pulse 2*NumbDataBits times per frame (plus once for parity), aligned with each OutputBit change.
REQ-019 In DONE, SHALL assert Done for one cycle with OutputBit=0, then return to IDLE; Start during that cycle SHALL be ignored.
REQ-020 Start while Busy=1 SHALL be ignored; input words SHALL NOT be resampled mid-frame.
REQ-021 Frame latency from Start edge to Done SHALL be 2*NumbDataBits*BitPeriod+1 cycles (+BitPeriod with PARITY_EN).
REQ-022 Abort=1 in any non-IDLE state SHALL return to IDLE on the next edge with Busy, OutputBit, BitStrobe at 0 and no Done pulse; Abort SHALL win over a simultaneous Start.
REQ-023 BitPeriod=1 SHALL give one bit per cycle with BitStrobe high continuously during the frame.

Reset
REQ-024 ClrN=0 SHALL immediately force IDLE, clear the shift register and counters, and drive Busy, BitStrobe, OutputBit, Done to 0, including mid-frame.
REQ-025 After ClrN deasserts, Start SHALL NOT be accepted before the first rising edge.

Configuration
REQ-026 With PARITY_EN defined, SHALL append one even-parity bit over all 2*NumbDataBits data bits, held BitPeriod cycles in PARITY, before DONE.
REQ-027 Without PARITY_EN, the PARITY state and its logic SHALL be absent and the frame SHALL end after the last data bit.

Structure
REQ-028 State encoding and default parameter constants SHALL live in shared package serializer_pkg.
REQ-029 The shift register SHALL be a sub-module tx_shift_reg (load, shift, MSB out); the FSM and counters SHALL stay in serial_tx_sequencer.

Verification (NumbDataBits=4, BitPeriod=2 unless stated)
REQ-030 Start with Input1=4'hA, Input2=4'h5 -> OutputBit 1,0,1,0,0,1,0,1, each held 2 cycles in cycles 1-16, BitStrobe on odd cycles, Done in cycle 17.
REQ-031 PARITY_EN, Input1=4'hA, Input2=4'h7 -> data 10100111, then parity bit 1 for 2 cycles, Done in cycle 19.
REQ-032 Start pulsed at cycle 5 of a frame -> ignored; single Done only; next Start after Done accepted.
REQ-033 Abort at cycle 7 -> Busy=0 and OutputBit=0 from cycle 8; Done never asserted.
REQ-034 ClrN low at cycle 9 -> all outputs 0 immediately with no clock; frame after release transmits correctly.
REQ-035 BitPeriod=1, Input1=4'hF, Input2=4'h0 -> 11110000 on cycles 1-8, BitStrobe high cycles 1-8, Done cycle 9.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared state encoding, default parameters and parity helper for the serial transmitter.
// Optional feature macro: PARITY_EN (appends one even-parity bit after the data bits).
package serializer_pkg;

    localparam int DEF_NUMB_DATA_BITS = 8;
    localparam int DEF_BIT_PERIOD     = 16;
    localparam int MAX_FRAME_BITS     = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } tx_state_e;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [MAX_FRAME_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Frame shift register: parallel load, left shift with zero fill, MSB presented as the serial bit.
// Optional feature macro: PARITY_EN (no local effect; parity words are loaded by the sequencer).
import serializer_pkg::*;

module tx_shift_reg #(
    parameter int Width = 2 * DEF_NUMB_DATA_BITS
) (
    input  logic             Clk,
    input  logic             ClrN,
    input  logic             load,
    input  logic             shift,
    input  logic             clr,
    input  logic [Width-1:0] din,
    output logic             msb
);

    logic [Width-1:0] sr_r;

    // Clear has priority over load, load over shift.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            sr_r <= {Width{1'b0}};
        end else if (clr) begin
            sr_r <= {Width{1'b0}};
        end else if (load) begin
            sr_r <= din;
        end else if (shift) begin
            sr_r <= {sr_r[Width-2:0], 1'b0};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign msb = sr_r[Width-1];

endmodule

// File: rtl/serial_tx_sequencer.sv
// Sends {Input1,Input2} MSB-first, each bit held BitPeriod cycles, then pulses Done.
// Optional feature macro: PARITY_EN (adds a PARITY state carrying one even-parity bit).
import serializer_pkg::*;

module serial_tx_sequencer #(
    parameter int NumbDataBits = DEF_NUMB_DATA_BITS,
    parameter int BitPeriod    = DEF_BIT_PERIOD
) (
    input  logic                    Clk,
    input  logic                    ClrN,
    input  logic [NumbDataBits-1:0] Input1,
    input  logic [NumbDataBits-1:0] Input2,
    input  logic                    Start,
    input  logic                    Abort,
    output logic                    Busy,
    output logic                    BitStrobe,
    output logic                    OutputBit,
    output logic                    Done
);

    localparam int FrameBits = 2 * NumbDataBits;
    localparam int BcWidth   = $clog2(FrameBits + 1);
    localparam int PcWidth   = (BitPeriod > 1) ? $clog2(BitPeriod) : 1;
    localparam logic [BcWidth-1:0] BC_LAST = BcWidth'(FrameBits - 1);
    localparam logic [PcWidth-1:0] PC_LAST = PcWidth'(BitPeriod - 1);

    tx_state_e          state_r;
    logic [BcWidth-1:0] bc_r;
    logic [PcWidth-1:0] pc_r;
    logic               busy_r;
    logic               strobe_r;
    logic               done_r;
`ifdef PARITY_EN
    logic               parity_r;
`endif

    logic [FrameBits-1:0] frame_s;
    logic [FrameBits-1:0] sr_din_s;
    logic                 sr_load_s;
    logic                 sr_shift_s;
    logic                 sr_clr_s;
    logic                 accept_s;
    logic                 period_end_s;
    logic                 last_bit_s;

    assign frame_s      = {Input1, Input2};
    assign accept_s     = (state_r == ST_IDLE) && Start && !Abort;
    assign period_end_s = (pc_r == PC_LAST);
    assign last_bit_s   = (bc_r == BC_LAST);

    // Shift-register commands mirror the transitions taken by the FSM below.
    always_comb begin
        sr_load_s  = 1'b0;
        sr_shift_s = 1'b0;
        sr_clr_s   = 1'b0;
        sr_din_s   = frame_s;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) sr_load_s = 1'b1;
                else          sr_load_s = 1'b0;
            end
            ST_SHIFT: begin
                if (Abort) begin
                    sr_clr_s = 1'b1;
                end else if (period_end_s && last_bit_s) begin
`ifdef PARITY_EN
                    sr_load_s = 1'b1;
                    sr_din_s  = {parity_r, {(FrameBits-1){1'b0}}};
`else
                    sr_clr_s  = 1'b1;
`endif
                end else if (period_end_s) begin
                    sr_shift_s = 1'b1;
                end else begin
                    sr_shift_s = 1'b0;
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                if (Abort || period_end_s) sr_clr_s = 1'b1;
                else                       sr_clr_s = 1'b0;
            end
`endif
            default: sr_clr_s = 1'b1;
        endcase
    end

    tx_shift_reg #(.Width(FrameBits)) u_shift (
        .Clk   (Clk),
        .ClrN  (ClrN),
        .load  (sr_load_s),
        .shift (sr_shift_s),
        .clr   (sr_clr_s),
        .din   (sr_din_s),
        .msb   (OutputBit)
    );

    // Frame FSM with bit/period counters; strobe and done default low so they only pulse.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_r  <= ST_IDLE;
            bc_r     <= {BcWidth{1'b0}};
            pc_r     <= {PcWidth{1'b0}};
            busy_r   <= 1'b0;
            strobe_r <= 1'b0;
            done_r   <= 1'b0;
`ifdef PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            strobe_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r  <= ST_SHIFT;
                        bc_r     <= {BcWidth{1'b0}};
                        pc_r     <= {PcWidth{1'b0}};
                        busy_r   <= 1'b1;
                        strobe_r <= 1'b1;
`ifdef PARITY_EN
                        parity_r <= even_parity(MAX_FRAME_BITS'(frame_s));
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (Abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        bc_r    <= {BcWidth{1'b0}};
                        pc_r    <= {PcWidth{1'b0}};
                    end else if (period_end_s) begin
                        pc_r <= {PcWidth{1'b0}};
                        if (last_bit_s) begin
                            bc_r <= {BcWidth{1'b0}};
`ifdef PARITY_EN
                            state_r  <= ST_PARITY;
                            strobe_r <= 1'b1;
`else
                            state_r  <= ST_DONE;
                            done_r   <= 1'b1;
`endif
                        end else begin
                            bc_r     <= bc_r + BcWidth'(1);
                            strobe_r <= 1'b1;
                        end
                    end else begin
                        pc_r <= pc_r + PcWidth'(1);
                    end
                end
`ifdef PARITY_EN
                ST_PARITY: begin
                    if (Abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        pc_r    <= {PcWidth{1'b0}};
                    end else if (period_end_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        pc_r    <= {PcWidth{1'b0}};
                    end else begin
                        pc_r <= pc_r + PcWidth'(1);
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    bc_r    <= {BcWidth{1'b0}};
                    pc_r    <= {PcWidth{1'b0}};
                end
            endcase
        end
    end

    assign Busy      = busy_r;
    assign BitStrobe = strobe_r;
    assign Done      = done_r;

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Scoreboard bench: two sequencers (BitPeriod 2 and 1) share stimulus; a per-cycle trace model
// predicts {Busy,BitStrobe,OutputBit,Done}. Honours PARITY_EN when defined.
module tb_serial_tx_sequencer;

    localparam int N = 4;
    localparam int W = 2 * N;

    typedef struct packed {
        logic busy;
        logic strobe;
        logic out;
        logic done;
    } rec_t;

    logic         Clk = 1'b0;
    logic         ClrN = 1'b0;
    logic [N-1:0] Input1 = '0;
    logic [N-1:0] Input2 = '0;
    logic         Start = 1'b0;
    logic         Abort = 1'b0;
    logic         busy0, strobe0, out0, done0;
    logic         busy1, strobe1, out1, done1;

    int   vectors = 0;
    int   miscompares = 0;
    rec_t q0[$];
    rec_t q1[$];
    logic active0 = 1'b0;
    logic active1 = 1'b0;

    always #5 Clk = ~Clk;

    serial_tx_sequencer #(.NumbDataBits(N), .BitPeriod(2)) dut0 (
        .Clk(Clk), .ClrN(ClrN), .Input1(Input1), .Input2(Input2), .Start(Start), .Abort(Abort),
        .Busy(busy0), .BitStrobe(strobe0), .OutputBit(out0), .Done(done0));

    serial_tx_sequencer #(.NumbDataBits(N), .BitPeriod(1)) dut1 (
        .Clk(Clk), .ClrN(ClrN), .Input1(Input1), .Input2(Input2), .Start(Start), .Abort(Abort),
        .Busy(busy1), .BitStrobe(strobe1), .OutputBit(out1), .Done(done1));

    task automatic compare(input string name, input rec_t act, input rec_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: busy/strobe/out/done got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected trace of one accepted frame, from the cycle after the Start edge through Done.
    task automatic push_frame(input int inst, input int p, input logic [W-1:0] frame);
        int   nbits;
        int   k;
        rec_t r;
        nbits = W;
`ifdef PARITY_EN
        nbits = W + 1;
`endif
        for (int c = 0; c < nbits * p; c++) begin
            k        = c / p;
            r.busy   = 1'b1;
            r.strobe = ((c % p) == 0);
            r.out    = (k < W) ? frame[W-1-k] : ^frame;
            r.done   = 1'b0;
            if (inst == 0) q0.push_back(r);
            else           q1.push_back(r);
        end
        r = '{busy: 1'b1, strobe: 1'b0, out: 1'b0, done: 1'b1};
        if (inst == 0) q0.push_back(r);
        else           q1.push_back(r);
    endtask

    always @(negedge Clk) begin : mon0
        rec_t e;
        if (q0.size() > 0) begin e = q0.pop_front(); active0 = 1'b1; end
        else               begin e = '0;             active0 = 1'b0; end
        compare("dut0_cycle", {busy0, strobe0, out0, done0}, e);
    end

    always @(negedge Clk) begin : mon1
        rec_t e;
        if (q1.size() > 0) begin e = q1.pop_front(); active1 = 1'b1; end
        else               begin e = '0;             active1 = 1'b0; end
        compare("dut1_cycle", {busy1, strobe1, out1, done1}, e);
    end

    // Drive one cycle of inputs and let the model react as the DUT should on the coming edge.
    task automatic step(input logic s, input logic ab, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge Clk);
        #1;
        Start  = s;
        Abort  = ab;
        Input1 = a;
        Input2 = b;
        if (ab) begin
            if (active0) q0.delete();
            if (active1) q1.delete();
        end else if (s) begin
            if (!active0) push_frame(0, 2, {a, b});
            if (!active1) push_frame(1, 1, {a, b});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic frame(input logic [N-1:0] a, input logic [N-1:0] b);
        step(1'b1, 1'b0, a, b);
        idle(24);
    endtask

    initial begin
        rec_t zero_r;
        zero_r = '0;
        idle(3);
        @(negedge Clk); #1; ClrN = 1'b1;
        idle(2);

        frame(4'hA, 4'h5);
        frame(4'hA, 4'h7);
        frame(4'hF, 4'h0);

        // Start again at cycle 5 of a running frame must be ignored.
        step(1'b1, 1'b0, 4'h3, 4'hC);
        idle(4);
        step(1'b1, 1'b0, 4'hF, 4'hF);
        idle(20);
        frame(4'h6, 4'h9);

        // Abort at cycle 7.
        step(1'b1, 1'b0, 4'hB, 4'hD);
        idle(6);
        step(1'b0, 1'b1, 4'h0, 4'h0);
        idle(22);

        // Abort together with Start in idle: no frame.
        step(1'b1, 1'b1, 4'hE, 4'h1);
        idle(4);

        // Reset during cycle 9, between clock edges.
        step(1'b1, 1'b0, 4'hC, 4'h3);
        idle(8);
        @(posedge Clk);
        #2;
        ClrN = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        compare("reset_dut0", {busy0, strobe0, out0, done0}, zero_r);
        compare("reset_dut1", {busy1, strobe1, out1, done1}, zero_r);
        idle(3);
        @(negedge Clk); #1; ClrN = 1'b1;
        frame(4'h9, 4'h6);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) == 0, $urandom_range(39, 0) == 0,
                 N'($urandom), N'($urandom));
        end
        idle(25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
